// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : laser_pkg
// Description : Shared LaserDrop framing constants, enums and header decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package laser_pkg;

    localparam logic [7:0] SEQ_START = 8'hCC;
    localparam logic [7:0] SEQ_STOP  = 8'h55;
    localparam logic [7:0] SEQ_ACK   = 8'h11;
    localparam logic [7:0] SEQ_FAIL  = 8'hBB;
    localparam logic [7:0] SEQ_DONE  = 8'hAA;

    // Lengths count beats including the header beat.
    localparam logic [9:0] LEN_START = 10'd512;
    localparam logic [9:0] LEN_STOP  = 10'd6;
    localparam logic [9:0] LEN_ACK   = 10'd4;
    localparam logic [9:0] LEN_FAIL  = 10'd4;
    localparam logic [9:0] LEN_DONE  = 10'd2;

    typedef enum logic [2:0] {
        PKT_START = 3'd0,
        PKT_STOP  = 3'd1,
        PKT_ACK   = 3'd2,
        PKT_FAIL  = 3'd3,
        PKT_DONE  = 3'd4
    } pkt_type_t;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_UNKNOWN_HDR   = 3'd1,
        ERR_LANE_MISMATCH = 3'd2,
        ERR_TIMEOUT       = 3'd3,
        ERR_OVERFLOW      = 3'd4
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BODY    = 2'd1,
        ST_DISCARD = 2'd2
    } asm_state_t;

    typedef struct packed {
        logic       known;
        pkt_type_t  ptype;
        logic [9:0] len;
    } hdr_info_t;

    function automatic hdr_info_t hdr_decode(input logic [7:0] seq);
        hdr_info_t info;
        info = '{known: 1'b1, ptype: PKT_START, len: LEN_START};
        case (seq)
            SEQ_START: info = '{known: 1'b1, ptype: PKT_START, len: LEN_START};
            SEQ_STOP:  info = '{known: 1'b1, ptype: PKT_STOP,  len: LEN_STOP};
            SEQ_ACK:   info = '{known: 1'b1, ptype: PKT_ACK,   len: LEN_ACK};
            SEQ_FAIL:  info = '{known: 1'b1, ptype: PKT_FAIL,  len: LEN_FAIL};
            SEQ_DONE:  info = '{known: 1'b1, ptype: PKT_DONE,  len: LEN_DONE};
            default:   info = '{known: 1'b0, ptype: PKT_START, len: 10'd0};
        endcase
        return info;
    endfunction

endpackage
`default_nettype wire

// File: rtl/laser_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module      : laser_beat_fifo
// Description : Registered synchronous FIFO of {last, lane2, lane1} beats.
// Revision    : 1.0 - initial release
// ============================================================================
module laser_beat_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH      = 17
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/laser_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module      : laser_packet_assembler
// Description : Frames receiver byte pairs into LaserDrop packets with status.
// Revision    : 1.0 - initial release
// ============================================================================
module laser_packet_assembler
    import laser_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_valid,
    input  logic [7:0]  data1_in,
    input  logic [7:0]  data2_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        pkt_done,
    output logic [2:0]  pkt_type,
    output logic        pkt_error,
    output logic [2:0]  err_code
);

    localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    asm_state_t  state_q, state_d;
    logic [9:0]  beat_cnt_q, beat_cnt_d;
    logic [9:0]  pkt_len_q, pkt_len_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    pkt_type_t   pkt_type_q, pkt_type_d;
    err_code_t   err_q, err_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        fifo_push;
    logic        fifo_last;
    logic        fifo_full;
    logic        fifo_empty;
    logic [16:0] fifo_head;
    hdr_info_t   hdr;

    assign hdr = hdr_decode(data1_in);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        pkt_len_d  = pkt_len_q;
        idle_cnt_d = idle_cnt_q;
        pkt_type_d = pkt_type_q;
        err_d      = err_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        fifo_push  = 1'b0;
        fifo_last  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (data_valid) begin
                    // Full is judged before any same-cycle pop so the drop decision is registered-state only.
                    if (fifo_full || (data2_in != data1_in) || !hdr.known) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                        state_d = ST_DISCARD;
                        if (fifo_full)                   err_d = ERR_OVERFLOW;
                        else if (data2_in != data1_in)   err_d = ERR_LANE_MISMATCH;
                        else                             err_d = ERR_UNKNOWN_HDR;
                    end else begin
                        fifo_push  = 1'b1;
                        beat_cnt_d = 10'd1;
                        pkt_len_d  = hdr.len;
                        pkt_type_d = hdr.ptype;
                        state_d    = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (data_valid) begin
                    idle_cnt_d = '0;
                    if (fifo_full) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                        err_d   = ERR_OVERFLOW;
                        state_d = ST_DISCARD;
                    end else begin
                        fifo_push  = 1'b1;
                        beat_cnt_d = beat_cnt_q + 10'd1;
                        if (beat_cnt_q + 10'd1 == pkt_len_q) begin
                            fifo_last = 1'b1;
                            done_d    = 1'b1;
                            err_d     = ERR_NONE;
                            state_d   = ST_IDLE;
                        end
                    end
                end else if (idle_cnt_q == TO_LAST) begin
                    done_d     = 1'b1;
                    error_d    = 1'b1;
                    err_d      = ERR_TIMEOUT;
                    idle_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            ST_DISCARD: begin
                if (data_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == TO_LAST) begin
                    idle_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                idle_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            pkt_len_q  <= '0;
            idle_cnt_q <= '0;
            pkt_type_q <= PKT_START;
            err_q      <= ERR_NONE;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_len_q  <= pkt_len_d;
            idle_cnt_q <= idle_cnt_d;
            pkt_type_q <= pkt_type_d;
            err_q      <= err_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    laser_beat_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (17)
    ) u_fifo (
        .clock_i (clock),
        .reset_i (reset),
        .push_i  (fifo_push),
        .data_i  ({fifo_last, data2_in, data1_in}),
        .pop_i   (out_ready),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head is masked while empty so stale storage never appears on the outputs.
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 16'd0 : fifo_head[15:0];
    assign out_last  = !fifo_empty && fifo_head[16];
    assign pkt_done  = done_q;
    assign pkt_error = error_q;
    assign pkt_type  = pkt_type_q;
    assign err_code  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_laser_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser_packet_assembler
// Description : Self-checking bench; packet-level reference queue vs. DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_packet_assembler;

    localparam int DEPTH = 16;
    localparam int TO    = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        data_valid = 1'b0;
    logic [7:0]  data1_in = 8'd0;
    logic [7:0]  data2_in = 8'd0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        pkt_done;
    logic [2:0]  pkt_type;
    logic        pkt_error;
    logic [2:0]  err_code;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    int delivered = 0;
    logic [16:0] exp_q [$];

    // Index = packet type code: START, STOP, ACK, FAIL, DONE.
    logic [7:0] hdr_tab [5] = '{8'hCC, 8'h55, 8'h11, 8'hBB, 8'hAA};
    int         len_tab [5] = '{512, 6, 4, 4, 2};

    laser_packet_assembler #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data_valid (data_valid),
        .data1_in   (data1_in),
        .data2_in   (data2_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .pkt_done   (pkt_done),
        .pkt_type   (pkt_type),
        .pkt_error  (pkt_error),
        .err_code   (err_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer side: every handshake must match the head of the reference queue.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("out_beat", 32'({out_last, out_data}), 32'(e));
                delivered++;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        case (rdy_mode)
            1:       out_ready = 1'($urandom_range(1, 0));
            2:       out_ready = ~out_ready;
            default: ;
        endcase
    endtask

    task automatic send_beat(input logic [7:0] d1, input logic [7:0] d2);
        data_valid = 1'b1;
        data1_in   = d1;
        data2_in   = d2;
        step();
        data_valid = 1'b0;
    endtask

    task automatic send_pkt(input int t, input int gmin, input int gmax);
        int         len;
        logic [7:0] d1, d2;
        len = len_tab[t];
        for (int i = 0; i < len; i++) begin
            d1 = (i == 0) ? hdr_tab[t] : 8'($urandom);
            d2 = (i == 0) ? hdr_tab[t] : 8'($urandom);
            exp_q.push_back({(i == len - 1), d2, d1});
            send_beat(d1, d2);
            if (i == len - 1) begin
                chk("pkt_done_end", 32'(pkt_done), 32'd1);
                chk("pkt_error_end", 32'(pkt_error), 32'd0);
                chk("pkt_type_end", 32'(pkt_type), 32'(t));
                chk("err_code_end", 32'(err_code), 32'd0);
            end else begin
                chk("pkt_done_mid", 32'(pkt_done), 32'd0);
                repeat ($urandom_range(gmax, gmin)) step();
            end
        end
    endtask

    task automatic drain();
        rdy_mode  = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 64 && exp_q.size() != 0; k++) step();
        step();
        chk("drained", 32'(exp_q.size()), 32'd0);
        chk("out_valid_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] a, b;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_pkt_done", 32'(pkt_done), 32'd0);
        chk("rst_pkt_type", 32'(pkt_type), 32'd0);
        chk("rst_pkt_error", 32'(pkt_error), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        reset = 1'b0;
        step();

        // ACK packet with the consumer always ready
        out_ready = 1'b1;
        send_pkt(2, 0, 0);
        drain();
        chk("ack_delivered", 32'(delivered), 32'd4);

        // Random short packets, random gaps, random consumer back-pressure
        for (int n = 0; n < 8; n++) begin
            rdy_mode = 1;
            send_pkt(int'($urandom_range(4, 1)), 0, 3);
            drain();
        end

        // START packet: a beat every second cycle, ready alternating
        delivered = 0;
        rdy_mode  = 2;
        send_pkt(0, 1, 1);
        drain();
        chk("start_delivered", 32'(delivered), 32'd512);

        // Unknown header then body beats: all swallowed
        send_beat(8'h42, 8'h42);
        chk("unk_done", 32'(pkt_done), 32'd1);
        chk("unk_error", 32'(pkt_error), 32'd1);
        chk("unk_code", 32'(err_code), 32'd1);
        for (int i = 0; i < 5; i++) begin
            send_beat(8'($urandom), 8'($urandom));
            chk("discard_no_done", 32'(pkt_done), 32'd0);
            chk("discard_no_valid", 32'(out_valid), 32'd0);
        end
        // One cycle short of the quiet period: the header is still discarded
        repeat (TO - 1) step();
        send_beat(8'h11, 8'h11);
        chk("early_hdr_valid", 32'(out_valid), 32'd0);
        chk("early_hdr_done", 32'(pkt_done), 32'd0);
        repeat (TO) step();
        send_pkt(2, 0, 2);
        drain();

        // Lane mismatch on a known sequence byte
        send_beat(8'hCC, 8'hCD);
        chk("lane_done", 32'(pkt_done), 32'd1);
        chk("lane_error", 32'(pkt_error), 32'd1);
        chk("lane_code", 32'(err_code), 32'd2);
        chk("lane_no_valid", 32'(out_valid), 32'd0);
        repeat (TO) step();

        // STOP header + 2 beats then silence: timeout
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 8'h55 : 8'($urandom);
            b = (i == 0) ? 8'h55 : 8'($urandom);
            exp_q.push_back({1'b0, b, a});
            send_beat(a, b);
        end
        for (int k = 1; k < TO; k++) begin
            step();
            chk("to_no_early_done", 32'(pkt_done), 32'd0);
        end
        step();
        chk("to_done", 32'(pkt_done), 32'd1);
        chk("to_error", 32'(pkt_error), 32'd1);
        chk("to_code", 32'(err_code), 32'd3);
        chk("to_fifo_holds", 32'(out_valid), 32'd1);
        step();
        chk("to_done_pulse", 32'(pkt_done), 32'd0);
        // Immediately back in IDLE: a header is accepted at once
        send_pkt(4, 0, 0);
        drain();

        // Fill the FIFO with DONE packets, then overflow
        out_ready = 1'b0;
        for (int n = 0; n < DEPTH / 2; n++) send_pkt(4, 0, 0);
        send_beat(8'hAA, 8'hAA);
        chk("ovf_done", 32'(pkt_done), 32'd1);
        chk("ovf_error", 32'(pkt_error), 32'd1);
        chk("ovf_code", 32'(err_code), 32'd4);
        send_beat(8'hAA, 8'hAA);
        chk("ovf_discard_no_done", 32'(pkt_done), 32'd0);
        chk("ovf_fifo_full_valid", 32'(out_valid), 32'd1);

        // Asynchronous reset mid-discard
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_last", 32'(out_last), 32'd0);
        chk("arst_pkt_done", 32'(pkt_done), 32'd0);
        chk("arst_pkt_type", 32'(pkt_type), 32'd0);
        chk("arst_pkt_error", 32'(pkt_error), 32'd0);
        chk("arst_err_code", 32'(err_code), 32'd0);
        exp_q.delete();
        @(posedge clock);
        #1 reset = 1'b0;

        // After reset the assembler is IDLE with an empty FIFO
        out_ready = 1'b1;
        send_pkt(3, 0, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
